alu_control_mc: RTL and testbench
=================================

ALU_CONTROL_MC -- requirements
Module: alu_control_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width (legal range 8..64).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the width of the iteration counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port valid_in, input, 1, which qualifies Funct/ALUOP/A/B as a new operation.
REQ-006 The block SHALL have port Funct, input, 6, the R-type function field.
REQ-007 The block SHALL have port ALUOP, input, 3, the operation class from main control.
REQ-008 The block SHALL have ports A and B, input, WIDTH each, the operands for multi-cycle multiply/divide.
REQ-009 The block SHALL have port Sel, output, 4, the registered ALU select.
REQ-010 The block SHALL have port illegal, output, 1, registered; indicates an undecodable operation.
REQ-011 The block SHALL have port stall, output, 1, high while a multiply/divide iterates.
REQ-012 The block SHALL have ports result and result_hi, output, WIDTH each: low product/quotient and high product/remainder.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse when result/result_hi are valid.
REQ-014 The block SHALL have port dz, output, 1, divide-by-zero flag, valid with done.

Function
REQ-015 The block SHALL accept an operation on a rising edge with valid_in=1 and state IDLE or DONE; valid_in is ignored in MUL/DIV.
REQ-016 On acceptance, Sel SHALL be loaded the next cycle: ALUOP 000->0001, 001->0010, 011->0101, 100->1000, 101->0110, 110/111->0000 with illegal=1.
REQ-017 For ALUOP=010, Funct SHALL map 000000->0000, 100000->0001, 100010->0010, 011001->0011, 011010->0100, 100100->0101, 100101->0110, 100111->0111, 101010->1000, 100110->1001; any other Funct yields Sel=0000 with illegal=1.
REQ-018 illegal SHALL be 0 on every accepted legal operation, and Sel/illegal SHALL hold their value until the next acceptance.
REQ-019 The FSM SHALL have states IDLE, MUL, DIV, DONE; an accepted Sel 0011 goes to MUL and 0100 to DIV, any other accepted operation stays in/returns to IDLE.
REQ-020 MUL SHALL be an unsigned shift-add over exactly WIDTH cycles, producing the 2*WIDTH-bit product as {result_hi, result}.
REQ-021 DIV SHALL be an unsigned restoring division over exactly WIDTH cycles, giving quotient in result and remainder in result_hi.
REQ-022 If B=0 on a DIV acceptance, the block SHALL still take WIDTH cycles, then give result = all ones, result_hi = A, dz=1; otherwise dz=0.
REQ-023 The counter SHALL clear on acceptance and increment in MUL/DIV; at count WIDTH-1 the next state SHALL be DONE.
REQ-024 Timing: accept at edge k; stall=1 for cycles k+1..k+WIDTH; done=1 only in cycle k+WIDTH+1 (state DONE).
REQ-025 stall SHALL be decoded from the state register only (MUL or DIV), with no combinational path from inputs.
REQ-026 result/result_hi/dz SHALL hold after done until the next multiply/divide completes.
REQ-027 DONE SHALL last one cycle and then go to IDLE, unless valid_in=1 in DONE, which is accepted back-to-back per REQ-019.

Reset
REQ-028 While rst=1, Sel=0000, illegal=0, stall=0, done=0, dz=0, result=0, result_hi=0, counter=0, state=IDLE, asynchronously.
REQ-029 rst asserted mid-operation SHALL abort it with no done pulse; the first edge after deassertion may accept a new operation.

Verification (WIDTH=32)
REQ-030 ALUOP=010, Funct=100000, valid_in=1 -> next cycle Sel=0001, illegal=0, stall=0.
REQ-031 ALUOP=010, Funct=111111 -> Sel=0000, illegal=1; then ALUOP=101 -> Sel=0110, illegal=0.
REQ-032 MUL A=7, B=6 -> stall high 32 cycles, done at k+33 with result=42, result_hi=0; and A=B=FFFFFFFF -> result=00000001, result_hi=FFFFFFFE.
REQ-033 DIV A=100, B=7 -> result=14, result_hi=2, dz=0; DIV A=5, B=0 -> result=FFFFFFFF, result_hi=5, dz=1.
REQ-034 rst pulsed at cycle k+10 of a MUL -> stall=0 immediately, no done pulse, all outputs 0.
REQ-035 valid_in toggled during stall is ignored; a new MUL with valid_in in the DONE cycle starts immediately with stall=1 the next cycle.

Source files
------------

// File: rtl/alu_control_mc.sv
// alu_control_mc: ALU select decoder with multi-cycle unsigned multiply/divide sequencer
module alu_control_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [5:0]       Funct,
  input  logic [2:0]       ALUOP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [3:0]       Sel,
  output logic             illegal,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             done,
  output logic             dz
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, b_r;
  logic [4:0] dec;
  logic accept, busy, last, div_ge;
  logic [WIDTH:0] mul_sum, div_sh;
  logic [WIDTH-1:0] div_df, nxt_hi, nxt_lo;
  assign busy   = (state == MUL) || (state == DIV);
  assign stall  = busy;
  assign accept = valid_in && ((state == IDLE) || (state == DONE));
  assign last   = cnt == CNT_W'(WIDTH - 1);
  // {illegal, Sel} decode of the incoming operation
  always_comb begin
    dec = 5'b10000;
    case (ALUOP)
      3'b000: dec = 5'b00001;
      3'b001: dec = 5'b00010;
      3'b011: dec = 5'b00101;
      3'b100: dec = 5'b01000;
      3'b101: dec = 5'b00110;
      3'b010:
        case (Funct)
          6'b000000: dec = 5'b00000;
          6'b100000: dec = 5'b00001;
          6'b100010: dec = 5'b00010;
          6'b011001: dec = 5'b00011;
          6'b011010: dec = 5'b00100;
          6'b100100: dec = 5'b00101;
          6'b100101: dec = 5'b00110;
          6'b100111: dec = 5'b00111;
          6'b101010: dec = 5'b01000;
          6'b100110: dec = 5'b01001;
          default:   dec = 5'b10000;
        endcase
      default: dec = 5'b10000;
    endcase
  end
  // one shift-add or restoring-divide step; hi/lo hold {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : '0);
    div_sh  = {hi, lo[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, b_r};
    div_df  = div_sh[WIDTH-1:0] - b_r;
    nxt_hi  = (state == MUL) ? mul_sum[WIDTH:1] : (div_ge ? div_df : div_sh[WIDTH-1:0]);
    nxt_lo  = (state == MUL) ? {mul_sum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], div_ge};
  end
  // sequencer: accept, iterate WIDTH steps, publish results with a one-cycle done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      Sel       <= '0;
      illegal   <= 1'b0;
      done      <= 1'b0;
      dz        <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      hi        <= '0;
      lo        <= '0;
      b_r       <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        Sel     <= dec[3:0];
        illegal <= dec[4];
        cnt     <= '0;
        hi      <= '0;
        lo      <= A;
        b_r     <= B;
        state   <= (dec[3:0] == 4'd3) ? MUL : (dec[3:0] == 4'd4) ? DIV : IDLE;
      end else if (busy) begin
        hi  <= nxt_hi;
        lo  <= nxt_lo;
        cnt <= cnt + 1'b1;
        if (last) begin
          state     <= DONE;
          done      <= 1'b1;
          result    <= nxt_lo;
          result_hi <= nxt_hi;
          dz        <= (state == DIV) && (b_r == '0);
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: randomized self-checking bench against a behavioural model
module tb_alu_control_mc;
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0;
  logic [5:0] Funct = '0;
  logic [2:0] ALUOP = '0;
  logic [31:0] A = '0, B = '0;
  logic [3:0] Sel;
  logic illegal, stall, done, dz;
  logic [31:0] result, result_hi;
  int checks = 0, failures = 0;
  logic [3:0] exp_sel = '0;
  logic exp_ill = 1'b0, exp_dz = 1'b0;
  logic [31:0] exp_res = '0, exp_hi = '0;
  logic [5:0] fns [10] = '{6'b000000, 6'b100000, 6'b100010, 6'b011001, 6'b011010,
                           6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b100110};
  alu_control_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .Funct(Funct), .ALUOP(ALUOP),
    .A(A), .B(B), .Sel(Sel), .illegal(illegal), .stall(stall),
    .result(result), .result_hi(result_hi), .done(done), .dz(dz)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // expected {illegal, Sel}: R-type select is the position of Funct in the table
  function automatic logic [4:0] ref_dec(input logic [2:0] op, input logic [5:0] fn);
    logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
    logic [3:0] sels [5] = '{4'd1, 4'd2, 4'd5, 4'd8, 4'd6};
    if (op == 3'b010) begin
      for (int i = 0; i < 10; i++) if (fns[i] == fn) return {1'b0, 4'(i)};
      return 5'b10000;
    end
    for (int i = 0; i < 5; i++) if (ops[i] == op) return {1'b0, sels[i]};
    return 5'b10000;
  endfunction
  task automatic check_hold(input string tag);
    check({tag, "_sel"}, 64'(Sel), 64'(exp_sel));
    check({tag, "_ill"}, 64'(illegal), 64'(exp_ill));
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    check({tag, "_hi"}, 64'(result_hi), 64'(exp_hi));
    check({tag, "_dz"}, 64'(dz), 64'(exp_dz));
  endtask
  // issue one operation; returns in the DONE cycle for multiply/divide, else in the cycle after acceptance
  task automatic do_op(input logic [2:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input bit noise);
    logic [63:0] p;
    valid_in = 1'b1; ALUOP = op; Funct = fn; A = a; B = b;
    tick();
    valid_in = 1'b0;
    {exp_ill, exp_sel} = ref_dec(op, fn);
    check("sel", 64'(Sel), 64'(exp_sel));
    check("illegal", 64'(illegal), 64'(exp_ill));
    if (exp_sel == 4'd3 || exp_sel == 4'd4) begin
      p = 64'(a) * 64'(b);
      if (exp_sel == 4'd3) {exp_hi, exp_res, exp_dz} = {p, 1'b0};
      else if (b == 0) {exp_hi, exp_res, exp_dz} = {a, 32'hFFFF_FFFF, 1'b1};
      else {exp_hi, exp_res, exp_dz} = {a % b, a / b, 1'b0};
      for (int i = 0; i < 32; i++) begin
        check("stall_busy", 64'(stall), 64'd1);
        check("done_busy", 64'(done), 64'd0);
        if (noise) begin
          valid_in = 1'($urandom); ALUOP = 3'($urandom); Funct = 6'($urandom);
          A = $urandom; B = $urandom;
        end
        tick();
      end
      valid_in = 1'b0;
      check("done_pulse", 64'(done), 64'd1);
      check("stall_done", 64'(stall), 64'd0);
      check_hold("fin");
    end else begin
      check("stall_nomd", 64'(stall), 64'd0);
      check("done_nomd", 64'(done), 64'd0);
      check_hold("nomd");
    end
  endtask
  task automatic idle();
    tick();
    check("done_idle", 64'(done), 64'd0);
    check("stall_idle", 64'(stall), 64'd0);
    check_hold("idle");
  endtask
  initial begin
    int r;
    logic [31:0] b;
    #2;
    check("rst_sel", 64'(Sel), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_hold("rst");
    tick();
    rst = 1'b0;
    do_op(3'b010, 6'b100000, 0, 0, 0);
    do_op(3'b010, 6'b111111, 0, 0, 0);
    do_op(3'b101, 6'b000000, 0, 0, 0);
    do_op(3'b110, 6'b000000, 0, 0, 0);
    do_op(3'b010, 6'b011001, 7, 6, 0);
    idle();
    do_op(3'b010, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    do_op(3'b010, 6'b011010, 100, 7, 0);
    do_op(3'b010, 6'b011010, 5, 0, 1);
    do_op(3'b010, 6'b011001, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    idle();
    idle();
    // reset in cycle k+10 of a multiply aborts it without a done pulse
    valid_in = 1'b1; ALUOP = 3'b010; Funct = 6'b011001; A = 7; B = 6;
    tick();
    valid_in = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    {exp_sel, exp_ill, exp_res, exp_hi, exp_dz} = '0;
    check("abort_stall", 64'(stall), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check_hold("abort");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("abort_nodone", 64'(done), 64'd0);
    end
    check_hold("post_abort");
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(3);
      b = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      case (r)
        0: do_op(3'b010, 6'b011001, $urandom, b, 1'($urandom));
        1: do_op(3'b010, 6'b011010, $urandom, b, 1'($urandom));
        2: do_op(3'($urandom), 6'($urandom), $urandom, b, 0);
        default: do_op(3'b010, ($urandom_range(1) == 1) ? fns[$urandom_range(9)] : 6'($urandom),
                       $urandom, b, 0);
      endcase
      if ($urandom_range(1) == 1) idle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
